count_capture_unit: RTL and testbench

- Downstream consumer of the user-project counter value.
- Watches the live count bus and detects when it equals a programmable compare value.
- On each match, snapshots the count into a small capture FIFO that the management SoC drains over Wishbone, and raises an interrupt while data is pending or an overflow is flagged.
- Sits beside the counter on the same clock, driving one bit of the user irq vector.

---
 rtl/count_capture_unit.sv | 193 +++++++++++++++++++
 tb/tb_count_capture_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_capture_unit.sv
// Compare-match capture unit: snapshots count_i into a FIFO on each rising match, Wishbone register access, level IRQ.
// Optional macro CAPTURE_TIMESTAMP_EN stores a 16-bit free-running timestamp with each captured count.
module count_capture_unit #(
    parameter int BITS  = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] count_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef CAPTURE_TIMESTAMP_EN
    localparam int EW = BITS + 16;
`else
    localparam int EW = BITS;
`endif
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_CMP    = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_DATA   = 2'd3;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return res;
    endfunction

    logic            en_r, irq_en_r, flush_r, ovf_r, match_q_r;
    logic [BITS-1:0] cmp_r;
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [EW-1:0]   mem_r [DEPTH];
`ifdef CAPTURE_TIMESTAMP_EN
    logic [15:0]     ts_r;
`endif

    logic            access_s, wr_s, rd_s, empty_s, full_s;
    logic            match_s, capture_s, pop_s, push_s, ovf_set_s, ovf_clr_s;
    logic [1:0]      reg_sel_s;
    logic [31:0]     cmp_word_s, head_word_s, rdata_s;
    logic [EW-1:0]   entry_s;
    logic            unused_s;

    assign unused_s = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], cmp_word_s[31:BITS]};

`ifdef CAPTURE_TIMESTAMP_EN
    assign entry_s = {ts_r, count_i};
`else
    assign entry_s = count_i;
`endif

    // Bus decode, match edge detection and FIFO push/pop arbitration.
    always_comb begin
        reg_sel_s  = wbs_adr_i[3:2];
        access_s   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
        wr_s       = access_s & wbs_we_i;
        rd_s       = access_s & ~wbs_we_i;
        empty_s    = (level_r == LEVEL_ZERO);
        full_s     = (level_r == LEVEL_FULL);
        match_s    = en_r & (count_i == cmp_r);
        // A capture landing on the flush cycle is discarded without flagging overflow.
        capture_s  = match_s & ~match_q_r & ~flush_r;
        pop_s      = rd_s & (reg_sel_s == ADR_DATA) & ~empty_s;
        push_s     = capture_s & (~full_s | pop_s);
        ovf_set_s  = capture_s & full_s & ~pop_s;
        ovf_clr_s  = wr_s & (reg_sel_s == ADR_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];
        cmp_word_s = byte_merge(32'(cmp_r), wbs_dat_i, wbs_sel_i);
    end

    // Format the FIFO head as a DATA register word.
    always_comb begin
        head_word_s = 32'd0;
        head_word_s[BITS-1:0] = mem_r[rd_ptr_r][BITS-1:0];
`ifdef CAPTURE_TIMESTAMP_EN
        head_word_s[31:16] = mem_r[rd_ptr_r][EW-1:BITS];
`endif
    end

    // Register read multiplexer.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_sel_s)
            ADR_CTRL:   rdata_s = {30'd0, irq_en_r, en_r};
            ADR_CMP:    rdata_s = 32'(cmp_r);
            ADR_STATUS: rdata_s = {18'd0, 6'(level_r), 5'd0, ovf_r, full_s, ~empty_s};
            ADR_DATA:   rdata_s = empty_s ? 32'd0 : head_word_s;
            default:    rdata_s = 32'd0;
        endcase
    end

    // Wishbone handshake and control/compare registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            en_r      <= 1'b0;
            irq_en_r  <= 1'b0;
            flush_r   <= 1'b0;
            cmp_r     <= {BITS{1'b0}};
        end else begin
            wbs_ack_o <= access_s;
            flush_r   <= 1'b0;
            if (rd_s) begin
                wbs_dat_o <= rdata_s;
            end
            if (wr_s) begin
                case (reg_sel_s)
                    ADR_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            en_r     <= wbs_dat_i[0];
                            irq_en_r <= wbs_dat_i[1];
                            flush_r  <= wbs_dat_i[2];
                        end
                    end
                    ADR_CMP: cmp_r <= cmp_word_s[BITS-1:0];
                    default: ;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush_r) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LEVEL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Match history, sticky overflow and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q_r <= 1'b0;
            ovf_r     <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            match_q_r <= match_s;
            ovf_r     <= ovf_set_s | (ovf_r & ~ovf_clr_s);
            irq_o     <= irq_en_r & (~empty_s | ovf_r);
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    // Free-running capture timestamp; flush leaves it running.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_r <= 16'd0;
        end else begin
            ts_r <= ts_r + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_count_capture_unit.sv
// Self-checking bench for count_capture_unit: queue-based reference model compared every cycle, plus directed literals.
module tb_count_capture_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] count_i = 16'd0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'd0;
    logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
    logic        wbs_ack_o, irq_o;
    logic [31:0] wbs_dat_o;

    int n_cmp = 0;
    int n_fail = 0;

    count_capture_unit #(.BITS(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .count_i(count_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q_m[$];
    logic        ack_m, irq_m, en_m, irq_en_m, ovf_m, prev_m, flush_m;
    logic [31:0] dat_m;
    logic [15:0] cmp_m, ts_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic acc, mt, cap, pop, ovf_set, ovf_clr;
        logic [1:0] a;
        logic [31:0] entry;
        int lvl;
        if (reset) begin
            q_m.delete();
            ack_m = 1'b0; irq_m = 1'b0; en_m = 1'b0; irq_en_m = 1'b0; ovf_m = 1'b0;
            prev_m = 1'b0; flush_m = 1'b0; dat_m = 32'd0; cmp_m = 16'd0; ts_m = 16'd0;
        end else begin
            lvl = q_m.size();
            a = wbs_adr_i[3:2];
            acc = wbs_cyc_i && wbs_stb_i && !ack_m;
            mt = en_m && (count_i == cmp_m);
            cap = mt && !prev_m && !flush_m;
            pop = acc && !wbs_we_i && (a == 2'd3) && (lvl > 0);
            entry = {16'd0, count_i};
`ifdef CAPTURE_TIMESTAMP_EN
            entry[31:16] = ts_m;
`endif
            irq_m = irq_en_m && ((lvl > 0) || ovf_m);
            if (acc && !wbs_we_i) begin
                case (a)
                    2'd0: dat_m = {30'd0, irq_en_m, en_m};
                    2'd1: dat_m = {16'd0, cmp_m};
                    2'd2: dat_m = {18'd0, 6'(lvl), 5'd0, ovf_m, (lvl == DEPTH), (lvl > 0)};
                    default: dat_m = pop ? q_m[0] : 32'd0;
                endcase
            end
            ovf_set = 1'b0;
            if (flush_m) begin
                q_m.delete();
            end else begin
                if (pop) void'(q_m.pop_front());
                if (cap) begin
                    if (q_m.size() < DEPTH) q_m.push_back(entry);
                    else ovf_set = 1'b1;
                end
            end
            ovf_clr = acc && wbs_we_i && (a == 2'd2) && wbs_sel_i[0] && wbs_dat_i[2];
            ovf_m = ovf_set || (ovf_m && !ovf_clr);
            flush_m = 1'b0;
            if (acc && wbs_we_i && (a == 2'd0) && wbs_sel_i[0]) begin
                en_m = wbs_dat_i[0];
                irq_en_m = wbs_dat_i[1];
                flush_m = wbs_dat_i[2];
            end
            if (acc && wbs_we_i && (a == 2'd1)) begin
                if (wbs_sel_i[0]) cmp_m[7:0] = wbs_dat_i[7:0];
                if (wbs_sel_i[1]) cmp_m[15:8] = wbs_dat_i[15:8];
            end
            ack_m = acc;
            prev_m = mt;
            ts_m = ts_m + 16'd1;
        end
    endtask

    // Advance the model on each rising edge, compare DUT outputs on the falling edge.
    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("ack", {31'd0, wbs_ack_o}, {31'd0, ack_m});
            check("irq", {31'd0, irq_o}, {31'd0, irq_m});
            check("rdata", wbs_dat_o, dat_m);
        end
    end

    task automatic wb(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                      input logic [31:0] wd, input logic set_cnt, input logic [15:0] cnt,
                      output logic [31:0] rd);
        bit got = 1'b0;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = {28'd0, adr, 2'b00}; wbs_sel_i = sel; wbs_dat_i = wd;
        if (set_cnt) count_i = cnt;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        rd = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] adr, input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] dummy;
        wb(1'b1, adr, sel, wd, 1'b0, 16'd0, dummy);
    endtask

    task automatic wb_rd(input logic [1:0] adr, output logic [31:0] rd);
        wb(1'b0, adr, 4'hF, 32'd0, 1'b0, 16'd0, rd);
    endtask

    task automatic pulse_count(input logic [15:0] v);
        @(negedge clk); count_i = v;
        @(negedge clk); count_i = 16'd0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        wb_rd(2'd0, rd); check("rst_ctrl", rd, 32'd0);
        wb_rd(2'd1, rd); check("rst_cmp", rd, 32'd0);
        wb_rd(2'd2, rd); check("rst_status", rd, 32'd0);
        wb_rd(2'd3, rd); check("rst_data", rd, 32'd0);

`ifdef CAPTURE_TIMESTAMP_EN
        // Capture while the timestamp reads 0x0123.
        wb_wr(2'd1, 4'hF, 32'h0000_0042);
        wb_wr(2'd0, 4'h1, 32'h0000_0001);
        for (int n = 0; n < 70000 && ts_m != 16'h0123; n++) @(negedge clk);
        count_i = 16'h0042;
        @(negedge clk); count_i = 16'd0;
        wb_rd(2'd3, rd); check("ts_data", rd, 32'h0123_0042);
`endif

        // Single match in a ramp.
        wb_wr(2'd1, 4'hF, 32'h0000_0005);
        wb_wr(2'd0, 4'h1, 32'h0000_0003);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); count_i = 16'(i);
        end
        @(negedge clk);
        check("ramp_irq", {31'd0, irq_o}, 32'd1);
        wb_rd(2'd2, rd); check("ramp_status", rd, 32'h0000_0101);
        wb_rd(2'd3, rd); check("ramp_data", {16'd0, rd[15:0]}, 32'h0000_0005);
        check("irq_pop_hold", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("irq_pop_drop", {31'd0, irq_o}, 32'd0);

        // Stalled count captures once.
        @(negedge clk); count_i = 16'd0;
        @(negedge clk); count_i = 16'h0005;
        repeat (20) @(negedge clk);
        wb_rd(2'd2, rd); check("stall_status", rd, 32'h0000_0101);
        wb_rd(2'd3, rd); check("stall_data", {16'd0, rd[15:0]}, 32'h0000_0005);
        count_i = 16'd0;

        // Ten captures into an 8-deep FIFO: overflow.
        for (int k = 1; k <= 10; k++) begin
            wb_wr(2'd1, 4'hF, 32'h10 + 32'(k));
            pulse_count(16'h10 + 16'(k));
        end
        wb_rd(2'd2, rd); check("ovf_status", rd, 32'h0000_0807);
        wb_wr(2'd2, 4'h1, 32'h0000_0004);
        wb_rd(2'd2, rd); check("ovf_cleared", rd, 32'h0000_0803);
        for (int k = 1; k <= 8; k++) begin
            wb_rd(2'd3, rd); check("ovf_pop", {16'd0, rd[15:0]}, 32'h10 + 32'(k));
        end
        wb_rd(2'd3, rd); check("empty_pop", rd, 32'd0);
        wb_rd(2'd2, rd); check("drained_status", rd, 32'd0);

        // Full FIFO: pop and match edge in the same cycle.
        for (int k = 1; k <= 8; k++) begin
            wb_wr(2'd1, 4'hF, 32'h20 + 32'(k));
            pulse_count(16'h20 + 16'(k));
        end
        wb_wr(2'd1, 4'hF, 32'h0000_0029);
        wb(1'b0, 2'd3, 4'hF, 32'd0, 1'b1, 16'h0029, rd);
        check("full_pop", {16'd0, rd[15:0]}, 32'h0000_0021);
        count_i = 16'd0;
        wb_rd(2'd2, rd); check("full_swap_status", rd, 32'h0000_0803);
        for (int k = 2; k <= 9; k++) begin
            wb_rd(2'd3, rd); check("full_drain", {16'd0, rd[15:0]}, 32'h20 + 32'(k));
        end

        // Flush with three entries; a capture on the flush cycle is discarded.
        for (int k = 1; k <= 3; k++) begin
            wb_wr(2'd1, 4'hF, 32'h30 + 32'(k));
            pulse_count(16'h30 + 16'(k));
        end
        wb_rd(2'd2, rd); check("pre_flush_status", rd, 32'h0000_0301);
        wb_wr(2'd1, 4'h1, 32'h0000_0044);
        wb_wr(2'd0, 4'h1, 32'h0000_0007);
        count_i = 16'h0044;
        check("flush_irq_hold", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        count_i = 16'd0;
        @(negedge clk);
        check("flush_irq_drop", {31'd0, irq_o}, 32'd0);
        wb_rd(2'd2, rd); check("flush_status", rd, 32'd0);
        wb_rd(2'd0, rd); check("flush_ctrl", rd, 32'h0000_0003);

        // Partial byte select on CMP.
        wb_wr(2'd1, 4'hF, 32'h0000_1234);
        wb_wr(2'd1, 4'h2, 32'hFFFF_AB99);
        wb_rd(2'd1, rd); check("cmp_bytesel", rd, 32'h0000_AB34);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
